// File: rtl/data_table_chain_delete.sv
// Hash-table chain delete engine: walks one bucket chain, unlinks the
// matching entry, clears its slot and returns it to empty-pointer storage.
module data_table_chain_delete #(
    parameter int KEY_W       = 32,
    parameter int VALUE_W     = 32,
    parameter int A_WIDTH     = 8,
    parameter int BUCKET_W    = 8,
    parameter int RAM_LATENCY = 2,
    parameter int MAX_CHAIN   = 16,
    parameter int CNT_W       = $clog2(MAX_CHAIN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [KEY_W-1:0]    task_key_i,
    input  logic [VALUE_W-1:0]  task_value_i,
    input  logic [BUCKET_W-1:0] task_bucket_i,
    input  logic [A_WIDTH-1:0]  task_head_ptr_i,
    input  logic                task_head_ptr_val_i,
    input  logic                task_valid_i,
    output logic                task_ready_o,
    output logic                rd_en_o,
    output logic [A_WIDTH-1:0]  rd_addr_o,
    input  logic [KEY_W-1:0]    rd_key_i,
    input  logic [VALUE_W-1:0]  rd_value_i,
    input  logic [A_WIDTH-1:0]  rd_next_ptr_i,
    input  logic                rd_next_ptr_val_i,
    output logic                wr_en_o,
    output logic [A_WIDTH-1:0]  wr_addr_o,
    output logic [KEY_W-1:0]    wr_key_o,
    output logic [VALUE_W-1:0]  wr_value_o,
    output logic [A_WIDTH-1:0]  wr_next_ptr_o,
    output logic                wr_next_ptr_val_o,
    output logic                head_wr_en_o,
    output logic [BUCKET_W-1:0] head_wr_addr_o,
    output logic [A_WIDTH-1:0]  head_wr_ptr_o,
    output logic                head_wr_ptr_val_o,
    output logic [A_WIDTH-1:0]  add_empty_ptr_o,
    output logic                add_empty_ptr_en_o,
    input  logic                add_empty_ptr_ready_i,
    output logic [KEY_W-1:0]    result_key_o,
    output logic [VALUE_W-1:0]  result_value_o,
    output logic [1:0]          result_code_o,
    output logic [CNT_W-1:0]    result_pos_o,
    output logic                result_valid_o,
    input  logic                result_ready_i
);

    localparam int WT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(RAM_LATENCY - 1);
    localparam logic [CNT_W-1:0] HOP_LAST = CNT_W'(MAX_CHAIN - 1);

    localparam logic [1:0] CODE_SUCCESS  = 2'd0;
    localparam logic [1:0] CODE_NO_ENTRY = 2'd1;
    localparam logic [1:0] CODE_LIMIT    = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CHECK,
        UNLINK,
        CLEAR,
        FREE,
        REPORT
    } state_t;

    state_t state;
    state_t next_state;

    logic [KEY_W-1:0]    lk_key;
    logic [VALUE_W-1:0]  lk_value;
    logic [BUCKET_W-1:0] lk_bucket;

    logic [A_WIDTH-1:0]  cur_addr;
    logic [KEY_W-1:0]    cur_key;
    logic [VALUE_W-1:0]  cur_value;
    logic [A_WIDTH-1:0]  cur_next;
    logic                cur_nval;

    logic [A_WIDTH-1:0]  prev_addr;
    logic [KEY_W-1:0]    prev_key;
    logic [VALUE_W-1:0]  prev_value;

    logic [CNT_W-1:0]    hop;
    logic [WT_W-1:0]     wait_cnt;
    logic [1:0]          res_code;
    logic [CNT_W-1:0]    res_pos;

    logic key_hit;
    logic wait_done;
    logic hop_limit;

    assign key_hit   = (cur_key == lk_key);
    assign wait_done = (wait_cnt == WT_LAST);
    assign hop_limit = (hop == HOP_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state         = state;
        task_ready_o       = 1'b0;
        rd_en_o            = 1'b0;
        rd_addr_o          = '0;
        wr_en_o            = 1'b0;
        wr_addr_o          = '0;
        wr_key_o           = '0;
        wr_value_o         = '0;
        wr_next_ptr_o      = '0;
        wr_next_ptr_val_o  = 1'b0;
        head_wr_en_o       = 1'b0;
        head_wr_addr_o     = '0;
        head_wr_ptr_o      = '0;
        head_wr_ptr_val_o  = 1'b0;
        add_empty_ptr_o    = '0;
        add_empty_ptr_en_o = 1'b0;
        result_key_o       = '0;
        result_value_o     = '0;
        result_code_o      = '0;
        result_pos_o       = '0;
        result_valid_o     = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated so the port reads 0 while reset is held.
                task_ready_o = rst_n_i;
                if (task_valid_i) begin
                    next_state = task_head_ptr_val_i ? RD_REQ : REPORT;
                end
            end
            RD_REQ: begin
                rd_en_o    = 1'b1;
                rd_addr_o  = cur_addr;
                next_state = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_done) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (key_hit) begin
                    next_state = UNLINK;
                end else if (!cur_nval || hop_limit) begin
                    next_state = REPORT;
                end else begin
                    next_state = RD_REQ;
                end
            end
            UNLINK: begin
                if (hop == '0) begin
                    head_wr_en_o      = 1'b1;
                    head_wr_addr_o    = lk_bucket;
                    head_wr_ptr_o     = cur_next;
                    head_wr_ptr_val_o = cur_nval;
                end else begin
                    // Predecessor inherits our link; same path for middle and tail.
                    wr_en_o           = 1'b1;
                    wr_addr_o         = prev_addr;
                    wr_key_o          = prev_key;
                    wr_value_o        = prev_value;
                    wr_next_ptr_o     = cur_next;
                    wr_next_ptr_val_o = cur_nval;
                end
                next_state = CLEAR;
            end
            CLEAR: begin
                wr_en_o    = 1'b1;
                wr_addr_o  = cur_addr;
                next_state = FREE;
            end
            FREE: begin
                add_empty_ptr_en_o = 1'b1;
                add_empty_ptr_o    = cur_addr;
                if (add_empty_ptr_ready_i) begin
                    next_state = REPORT;
                end
            end
            REPORT: begin
                result_valid_o = 1'b1;
                result_key_o   = lk_key;
                result_value_o = lk_value;
                result_code_o  = res_code;
                result_pos_o   = res_pos;
                if (result_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lk_key     <= '0;
            lk_value   <= '0;
            lk_bucket  <= '0;
            cur_addr   <= '0;
            cur_key    <= '0;
            cur_value  <= '0;
            cur_next   <= '0;
            cur_nval   <= 1'b0;
            prev_addr  <= '0;
            prev_key   <= '0;
            prev_value <= '0;
            hop        <= '0;
            wait_cnt   <= '0;
            res_code   <= '0;
            res_pos    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (task_valid_i) begin
                        lk_key    <= task_key_i;
                        lk_value  <= task_value_i;
                        lk_bucket <= task_bucket_i;
                        cur_addr  <= task_head_ptr_i;
                        hop       <= '0;
                        res_code  <= CODE_NO_ENTRY;
                        res_pos   <= '0;
                    end
                end
                RD_REQ: begin
                    wait_cnt <= '0;
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_done) begin
                        cur_key   <= rd_key_i;
                        cur_value <= rd_value_i;
                        cur_next  <= rd_next_ptr_i;
                        cur_nval  <= rd_next_ptr_val_i;
                    end
                end
                CHECK: begin
                    if (key_hit) begin
                        res_pos <= hop;
                    end else if (!cur_nval) begin
                        res_code <= CODE_NO_ENTRY;
                        res_pos  <= hop;
                    end else if (hop_limit) begin
                        res_code <= CODE_LIMIT;
                        res_pos  <= hop;
                    end else begin
                        prev_addr  <= cur_addr;
                        prev_key   <= cur_key;
                        prev_value <= cur_value;
                        cur_addr   <= cur_next;
                        hop        <= hop + 1'b1;
                    end
                end
                FREE: begin
                    if (add_empty_ptr_ready_i) begin
                        res_code <= CODE_SUCCESS;
                        res_pos  <= hop;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_table_chain_delete.sv
// Directed bench for data_table_chain_delete with a latency-L RAM model,
// table-driven delete vectors and hand sequences for backpressure and reset.
module tb_data_table_chain_delete;

    localparam int L     = 3;
    localparam int MAXC  = 4;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       task_key = '0;
    logic [31:0]       task_value = '0;
    logic [7:0]        task_bucket = '0;
    logic [7:0]        task_head_ptr = '0;
    logic              task_head_ptr_val = 1'b0;
    logic              task_valid = 1'b0;
    logic              task_ready;
    logic              rd_en;
    logic [7:0]        rd_addr;
    logic [31:0]       rd_key;
    logic [31:0]       rd_value;
    logic [7:0]        rd_next_ptr;
    logic              rd_next_ptr_val;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [31:0]       wr_key;
    logic [31:0]       wr_value;
    logic [7:0]        wr_next_ptr;
    logic              wr_next_ptr_val;
    logic              head_wr_en;
    logic [7:0]        head_wr_addr;
    logic [7:0]        head_wr_ptr;
    logic              head_wr_ptr_val;
    logic [7:0]        add_empty_ptr;
    logic              add_empty_ptr_en;
    logic              add_empty_ptr_ready = 1'b1;
    logic [31:0]       result_key;
    logic [31:0]       result_value;
    logic [1:0]        result_code;
    logic [CNT_W-1:0]  result_pos;
    logic              result_valid;
    logic              result_ready = 1'b1;

    data_table_chain_delete #(
        .KEY_W(32), .VALUE_W(32), .A_WIDTH(8), .BUCKET_W(8),
        .RAM_LATENCY(L), .MAX_CHAIN(MAXC)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .task_key_i(task_key), .task_value_i(task_value),
        .task_bucket_i(task_bucket), .task_head_ptr_i(task_head_ptr),
        .task_head_ptr_val_i(task_head_ptr_val),
        .task_valid_i(task_valid), .task_ready_o(task_ready),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr),
        .rd_key_i(rd_key), .rd_value_i(rd_value),
        .rd_next_ptr_i(rd_next_ptr), .rd_next_ptr_val_i(rd_next_ptr_val),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr),
        .wr_key_o(wr_key), .wr_value_o(wr_value),
        .wr_next_ptr_o(wr_next_ptr), .wr_next_ptr_val_o(wr_next_ptr_val),
        .head_wr_en_o(head_wr_en), .head_wr_addr_o(head_wr_addr),
        .head_wr_ptr_o(head_wr_ptr), .head_wr_ptr_val_o(head_wr_ptr_val),
        .add_empty_ptr_o(add_empty_ptr), .add_empty_ptr_en_o(add_empty_ptr_en),
        .add_empty_ptr_ready_i(add_empty_ptr_ready),
        .result_key_o(result_key), .result_value_o(result_value),
        .result_code_o(result_code), .result_pos_o(result_pos),
        .result_valid_o(result_valid), .result_ready_i(result_ready)
    );

    always #5 clk = ~clk;

    // Data RAM model: data appears exactly L cycles after the request
    logic [31:0] m_key [256];
    logic [31:0] m_val [256];
    logic [7:0]  m_nxt [256];
    logic        m_nv  [256];
    logic        pv [L];
    logic [7:0]  pa [L];

    initial begin
        for (int i = 0; i < L; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
    end

    always @(posedge clk) begin
        pv[0] <= rd_en;
        pa[0] <= rd_addr;
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        if (wr_en) begin
            m_key[wr_addr] <= wr_key;
            m_val[wr_addr] <= wr_value;
            m_nxt[wr_addr] <= wr_next_ptr;
            m_nv[wr_addr]  <= wr_next_ptr_val;
        end
    end

    assign rd_key          = pv[L-1] ? m_key[pa[L-1]] : 32'hDEAD_BEEF;
    assign rd_value        = pv[L-1] ? m_val[pa[L-1]] : 32'hDEAD_BEEF;
    assign rd_next_ptr     = pv[L-1] ? m_nxt[pa[L-1]] : 8'hEE;
    assign rd_next_ptr_val = pv[L-1] ? m_nv[pa[L-1]]  : 1'b1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] key;
        logic [31:0] value;
        logic [7:0]  nxt;
        logic        nv;
    } wr_t;

    wr_t        wr_q[$];
    int         rd_cnt;
    int         head_cnt;
    logic [7:0] h_addr;
    logic [7:0] h_ptr;
    logic       h_val;
    int         free_cnt;
    logic [7:0] free_addr;
    int         viol;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rd_en) rd_cnt++;
        if (wr_en) wr_q.push_back('{wr_addr, wr_key, wr_value, wr_next_ptr, wr_next_ptr_val});
        if (head_wr_en) begin
            head_cnt++;
            h_addr = head_wr_addr;
            h_ptr  = head_wr_ptr;
            h_val  = head_wr_ptr_val;
        end
        if (add_empty_ptr_en && add_empty_ptr_ready) begin
            free_cnt++;
            free_addr = add_empty_ptr;
        end
        if (wr_en && head_wr_en) viol++;
        if (!wr_en && (|{wr_addr, wr_key, wr_value, wr_next_ptr, wr_next_ptr_val})) viol++;
        if (!head_wr_en && (|{head_wr_addr, head_wr_ptr, head_wr_ptr_val})) viol++;
        if (!add_empty_ptr_en && (add_empty_ptr != 8'd0)) viol++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        wr_q.delete();
        rd_cnt   = 0;
        head_cnt = 0;
        free_cnt = 0;
        h_addr = '0;
        h_ptr = '0;
        h_val = 1'b0;
        free_addr = '0;
    endtask

    // setup 0: A(5)->B(9)->C(3); setup 1: self-loop at 7
    task automatic init_mem(input int setup);
        for (int i = 0; i < 256; i++) begin
            m_key[i] = 32'hFFFF_0000 | i;
            m_val[i] = '0;
            m_nxt[i] = '0;
            m_nv[i]  = 1'b0;
        end
        if (setup == 0) begin
            m_key[5] = 32'hA0; m_val[5] = 32'h1A; m_nxt[5] = 8'd9; m_nv[5] = 1'b1;
            m_key[9] = 32'hB0; m_val[9] = 32'h1B; m_nxt[9] = 8'd3; m_nv[9] = 1'b1;
            m_key[3] = 32'hC0; m_val[3] = 32'h1C; m_nxt[3] = 8'd0; m_nv[3] = 1'b0;
        end else begin
            m_key[7] = 32'h77; m_val[7] = 32'h17; m_nxt[7] = 8'd7; m_nv[7] = 1'b1;
        end
    endtask

    typedef struct {
        int   setup;
        int   bucket;
        int   hptr;
        int   hval;
        int   key;
        int   code;
        int   pos;
        int   lat;
        int   reads;
        int   heads;
        int   hp;
        int   hv;
        int   nwr;
        int   laddr;
        int   lkey;
        int   lval;
        int   lnext;
        int   lnv;
        int   nfree;
        int   faddr;
    } vec_t;

    vec_t vecs[6];

    // Issue one task; leaves the bench at cycle 1 (#1 after the accepting edge)
    task automatic issue(input int bucket, input int hptr, input int hval,
                         input int key, input int value);
        @(negedge clk);
        task_key          = 32'(key);
        task_value        = 32'(value);
        task_bucket       = 8'(bucket);
        task_head_ptr     = 8'(hptr);
        task_head_ptr_val = hval[0];
        task_valid        = 1'b1;
        @(posedge clk);
        #1;
        task_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        string n;
        n = $sformatf("v%0d", idx);
        init_mem(v.setup);
        clr_mon();
        issue(v.bucket, v.hptr, v.hval, v.key, 32'h5000 + idx);
        lat = 0;
        for (int c = 1; c <= 80; c++) begin
            if (result_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({n, "_latency"}, 64'(lat), 64'(v.lat));
        chk({n, "_code"}, 64'(result_code), 64'(v.code));
        chk({n, "_pos"}, 64'(result_pos), 64'(v.pos));
        chk({n, "_key_echo"}, 64'(result_key), 64'(v.key));
        chk({n, "_value_echo"}, 64'(result_value), 64'(32'h5000 + idx));
        chk({n, "_reads"}, 64'(rd_cnt), 64'(v.reads));
        chk({n, "_head_writes"}, 64'(head_cnt), 64'(v.heads));
        if (v.heads == 1) begin
            chk({n, "_head_fields"}, {h_addr, h_ptr, 7'd0, h_val},
                {8'(v.bucket), 8'(v.hp), 7'd0, v.hv[0]});
        end
        chk({n, "_data_writes"}, 64'(wr_q.size()), 64'(v.nwr));
        if (v.nwr == 2 && wr_q.size() == 2) begin
            chk({n, "_link_addr_ptr"}, {wr_q[0].addr, wr_q[0].nxt, 7'd0, wr_q[0].nv},
                {8'(v.laddr), 8'(v.lnext), 7'd0, v.lnv[0]});
            chk({n, "_link_data"}, {wr_q[0].key, wr_q[0].value},
                {32'(v.lkey), 32'(v.lval)});
        end
        if (v.nfree == 1 && wr_q.size() > 0) begin
            chk({n, "_clear"}, {wr_q[$].addr, 1'b0, |{wr_q[$].key, wr_q[$].value,
                wr_q[$].nxt, wr_q[$].nv}}, {8'(v.faddr), 2'b00});
        end
        chk({n, "_frees"}, {32'(free_cnt), 24'd0, free_addr},
            {32'(v.nfree), 24'd0, 8'(v.faddr)});
        @(posedge clk);
        #1;
        chk({n, "_back_to_idle"}, {62'd0, task_ready, result_valid}, 64'd2);
    endtask

    int bad;
    int lat2;

    initial begin
        viol = 0;
        clr_mon();
        init_mem(0);
        vecs[0] = '{0, 2, 0, 0, 'h11, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 4, 5, 1, 'hA0, 0, 0, 9, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0, 1, 5};
        vecs[2] = '{0, 4, 5, 1, 'hB0, 0, 1, 14, 2, 0, 0, 0, 2, 5, 'hA0, 'h1A, 3, 1, 1, 9};
        vecs[3] = '{0, 4, 5, 1, 'hC0, 0, 2, 19, 3, 0, 0, 0, 2, 9, 'hB0, 'h1B, 0, 0, 1, 3};
        vecs[4] = '{0, 4, 5, 1, 'h99, 1, 2, 16, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{1, 6, 7, 1, 'h55, 2, 3, 21, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        #1;
        chk("reset_outputs", {62'd0, task_ready, result_valid}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {62'd0, task_ready, result_valid}, 64'd2);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure on the free port and on the result port
        init_mem(0);
        clr_mon();
        add_empty_ptr_ready = 1'b0;
        result_ready = 1'b0;
        issue(4, 5, 1, 'hA0, 'h777);
        for (int c = 0; c < 40 && !add_empty_ptr_en; c++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_free_seen", {63'd0, add_empty_ptr_en}, 64'd1);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (!add_empty_ptr_en || add_empty_ptr != 8'd5 || task_ready || result_valid) bad++;
            @(posedge clk);
            #1;
        end
        chk("bp_free_held", 64'(bad), 64'd0);
        chk("bp_no_free_yet", 64'(free_cnt), 64'd0);
        add_empty_ptr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_free_done", 64'(free_cnt), 64'd1);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (!result_valid || result_code != 2'd0 || result_pos != '0 ||
                result_key != 32'hA0 || result_value != 32'h777 || task_ready) bad++;
            @(posedge clk);
            #1;
        end
        chk("bp_result_held", 64'(bad), 64'd0);
        chk("bp_result_still", {63'd0, result_valid}, 64'd1);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", {62'd0, task_ready, result_valid}, 64'd2);

        // Reset pulse in RD_WAIT aborts with no writes
        init_mem(0);
        clr_mon();
        issue(4, 5, 1, 'hB0, 'h888);
        @(posedge clk);
        #1;
        chk("rst_mid_rdwait_no_rd", {63'd0, rd_en}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_all_zero", {63'd0, |{task_ready, rd_en, rd_addr, wr_en, wr_addr,
            wr_key, wr_value, wr_next_ptr, wr_next_ptr_val, head_wr_en, head_wr_addr,
            head_wr_ptr, head_wr_ptr_val, add_empty_ptr, add_empty_ptr_en, result_key,
            result_value, result_code, result_pos, result_valid}}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_ready", {63'd0, task_ready}, 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_writes", 64'(wr_q.size() + head_cnt + free_cnt), 64'd0);
        chk("rst_mid_idle", {62'd0, task_ready, result_valid}, 64'd2);

        // Recovery: empty bucket straight after reset
        clr_mon();
        issue(1, 0, 0, 'h11, 'h999);
        lat2 = result_valid ? 1 : 0;
        chk("post_rst_empty", {32'(lat2), 30'd0, result_code}, {32'd1, 32'd1});

        chk("strobe_rules", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
